meta_wrr_sched: RTL
===================

Name: meta_wrr_sched

Overview:
- Shares the p2k lookup interface and the packet-address write path between two 340-bit metadata FIFOs: src0 = no-cut metadata, src1 = out metadata.
- Uses weighted round-robin with runtime-programmable weights.
- Downstream flow control is credit-based, so the lookup engine is never overrun.
- Sits between the two metadata FIFOs (normal-mode, q valid one cycle after rdreq) and the lookup/packet-address consumers.

Parameters:
- CREDIT_MAX, 8: downstream lookup slots; credit counter reset value and ceiling (1..15).
- WGT_W, 4: width of each weight input.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- src0_empty  in  1  src0 FIFO empty
- src0_rdreq  out  1  src0 FIFO read request (1-cycle pulse)
- src0_q  in  340  src0 FIFO data
- src1_empty  in  1  src1 FIFO empty
- src1_rdreq  out  1  src1 FIFO read request (1-cycle pulse)
- src1_q  in  340  src1 FIFO data
- cfg_weight0  in  WGT_W  consecutive grants allowed to src0 per turn; 0 is treated as 1
- cfg_weight1  in  WGT_W  same, for src1
- credit_ret  in  1  one lookup completed downstream; returns one credit
- pkt_addr  out  5  {granted src, q[339:336]}
- pkt_addr_wr  out  1  pkt_addr strobe
- p2k_valid  out  1  lookup request strobe
- p2k_ingress  out  8  q[335:328]
- p2k_rloc_src  out  128  q[327:200]
- p2k_eid_dst  out  128  q[199:72]
- p2k_metadata  out  72  q[71:0]
- credit_cnt  out  4  current credits
- credit_err  out  1  sticky: credit returned while credit_cnt == CREDIT_MAX
- gnt_cnt0  out  32  src0 grant count (optional feature)
- gnt_cnt1  out  32  src1 grant count (optional feature)

Behaviour:
- Reset (async, reset=0): all outputs 0, except credit_cnt = CREDIT_MAX. Internal state: state=ARB, cur_src=0, run_cnt=0.
- Weights are sampled in ARB each cycle. A change takes effect at the next arbitration.
- ARB state: a grant is possible only if credit_cnt > 0. Selection order:
  - (a) cur_src non-empty and run_cnt < weight(cur_src): grant cur_src, run_cnt++.
  - (b) otherwise, the other source non-empty: cur_src flips, run_cnt = 1.
  - (c) otherwise, cur_src non-empty with its weight exhausted: grant cur_src, run_cnt = 1 (work-conserving).
  - (d) otherwise: no grant; stay in ARB.
- On a grant in ARB:
  - Pulse the granted srcX_rdreq for exactly one cycle.
  - Decrement credit_cnt.
  - Go to CAP.
- CAP state:
  - Register the granted q fields onto the p2k_* and pkt_addr outputs.
  - Assert pkt_addr_wr and p2k_valid for exactly one cycle.
  - Return to ARB.
- Idle outputs: strobes are 0 outside the CAP output cycle. Data outputs hold their last values; they are not zeroed.
- Latency and throughput: rdreq to p2k_valid is 2 cycles; at most one grant per 2 cycles.
- Credits:
  - Grant and credit_ret in the same cycle: credit_cnt unchanged.
  - credit_ret with no grant: +1, saturating at CREDIT_MAX. A return at the ceiling sets credit_err, which clears only on reset.
  - credit_cnt == 0: ARB stalls. A same-cycle credit_ret does not unblock that cycle; arbitration resumes the next cycle.
- Both sources empty: no rdreq is issued; cur_src and run_cnt are retained.
- Reset mid-operation (including in CAP): the pending output is discarded with no strobe. The FIFOs are cleared by the same reset in the parent.

Optional Feature:
- META_SCHED_STATS_EN defined:
  - gnt_cnt0 and gnt_cnt1 increment on each p2k_valid for the respective source.
  - 32-bit, wrap to 0 after 0xFFFFFFFF; reset to 0.
- Not defined: gnt_cnt0 and gnt_cnt1 are tied to 0 and no counter flops are built. All other behaviour is identical.

Test Plan:
- Single entry on src0 with q[339:336]=4'hA, q[335:328]=8'h21, other src empty → src0_rdreq for 1 cycle, then 2 cycles after rdreq: p2k_valid=1, pkt_addr=5'h0A, p2k_ingress=8'h21. src1 entry → pkt_addr=5'h1A.
- Both sources backlogged, weight0=3, weight1=1, credits never exhausted (credit_ret each grant) → repeating grant pattern 0,0,0,1; 8 grants give src0=6, src1=2.
- weight0=0, weight1=0, both backlogged → strict alternation 0,1,0,1 (0 treated as 1).
- CREDIT_MAX=8, no credit_ret, src0 holds 10 entries → exactly 8 p2k_valid then stall with credit_cnt=0. One credit_ret → exactly one more grant, starting the cycle after the return.
- credit_ret pulsed at reset (credit_cnt=8) → credit_cnt stays 8 and credit_err=1 until reset. Grant and credit_ret in the same cycle at credit_cnt=5 → stays 5.
- Reset asserted in CAP with an entry pending → no p2k_valid. All outputs 0 and credit_cnt=CREDIT_MAX during reset. With META_SCHED_STATS_EN, after 5 src1 grants: gnt_cnt1=5, gnt_cnt0=0.

Source files
------------

// File: rtl/meta_wrr_sched.sv
// ---------------------------------------------------------------------------
// meta_wrr_sched
//
// Purpose:
//   Shares one p2k lookup interface and one packet-address write path between
//   two 340-bit metadata FIFOs (src0 = no-cut metadata, src1 = out metadata).
//   The arbiter is a weighted round-robin with runtime weights. Downstream
//   lookup slots are tracked with a credit counter, so the lookup engine is
//   never overrun.
//
//   Flow per grant: ARB cycle pulses srcX_rdreq, the FIFO presents q in the
//   following CAP cycle, q is registered onto the outputs, and
//   p2k_valid/pkt_addr_wr are high in the cycle after CAP. rdreq to p2k_valid
//   is therefore 2 cycles, with at most one grant every 2 cycles.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   srcN_empty/_rdreq/_q  FIFO interface for source N (normal-mode FIFO,
//                       q valid one cycle after rdreq)
//   cfg_weight0/1       consecutive grants per turn (0 behaves as 1)
//   credit_ret          one downstream lookup completed
//   pkt_addr, pkt_addr_wr   {granted src, q[339:336]} and its strobe
//   p2k_valid, p2k_*    lookup request strobe and registered q fields
//   credit_cnt          current credits
//   credit_err          sticky: credit returned while already at CREDIT_MAX
//   gnt_cnt0/1          per-source grant counters
//
// Build option:
//   META_SCHED_STATS_EN  when defined, gnt_cnt0/1 count p2k_valid strobes per
//                        source (32-bit, wrapping). When undefined they are
//                        tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module meta_wrr_sched #(
    parameter int unsigned CREDIT_MAX = 8,
    parameter int unsigned WGT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src0_empty,
    output logic             src0_rdreq,
    input  logic [339:0]     src0_q,
    input  logic             src1_empty,
    output logic             src1_rdreq,
    input  logic [339:0]     src1_q,
    input  logic [WGT_W-1:0] cfg_weight0,
    input  logic [WGT_W-1:0] cfg_weight1,
    input  logic             credit_ret,
    output logic [4:0]       pkt_addr,
    output logic             pkt_addr_wr,
    output logic             p2k_valid,
    output logic [7:0]       p2k_ingress,
    output logic [127:0]     p2k_rloc_src,
    output logic [127:0]     p2k_eid_dst,
    output logic [71:0]      p2k_metadata,
    output logic [3:0]       credit_cnt,
    output logic             credit_err,
    output logic [31:0]      gnt_cnt0,
    output logic [31:0]      gnt_cnt1
);

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_CAP = 1'b1
    } state_t;

    localparam logic [3:0] CREDIT_CEIL = 4'(CREDIT_MAX);

    state_t           state_q, state_d;
    logic             cur_src_q, cur_src_d;
    logic [WGT_W-1:0] run_cnt_q, run_cnt_d;
    logic [3:0]       credit_q, credit_d;
    logic             credit_err_q, credit_err_d;
    logic             grant;

    logic [4:0]       pkt_addr_q;
    logic             strobe_q;
    logic [7:0]       ingress_q;
    logic [127:0]     rloc_q;
    logic [127:0]     eid_q;
    logic [71:0]      meta_q;

    // Per-source availability and effective weight (a zero weight means one
    // grant per turn, so a misprogrammed source can never be starved).
    logic [1:0]            src_avail;
    logic [1:0][WGT_W-1:0] wgt_raw;
    logic [1:0][WGT_W-1:0] wgt_eff;

    assign src_avail = {~src1_empty, ~src0_empty};
    assign wgt_raw   = {cfg_weight1, cfg_weight0};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wgt
            assign wgt_eff[gi] = (wgt_raw[gi] == '0) ? WGT_W'(1) : wgt_raw[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Arbitration / FSM next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cur_src_d = cur_src_q;
        run_cnt_d = run_cnt_q;
        grant     = 1'b0;
        case (state_q)
            ST_ARB: begin
                // A credit returned this cycle is not usable until next cycle.
                if (credit_q != 4'd0) begin
                    if (src_avail[cur_src_q] && (run_cnt_q < wgt_eff[cur_src_q])) begin
                        grant     = 1'b1;
                        run_cnt_d = run_cnt_q + WGT_W'(1);
                    end else if (src_avail[~cur_src_q]) begin
                        grant     = 1'b1;
                        cur_src_d = ~cur_src_q;
                        run_cnt_d = WGT_W'(1);
                    end else if (src_avail[cur_src_q]) begin
                        // Weight used up but the other side is idle: keep
                        // serving and start a fresh turn.
                        grant     = 1'b1;
                        run_cnt_d = WGT_W'(1);
                    end
                end
                if (grant) begin
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                state_d = ST_ARB;
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    // rdreq is combinational so the FIFO's q lands in the CAP cycle. It is
    // gated with reset so nothing is requested while the block is held.
    assign src0_rdreq = reset & grant & ~cur_src_d;
    assign src1_rdreq = reset & grant &  cur_src_d;

    // -----------------------------------------------------------------------
    // Credit counter
    // -----------------------------------------------------------------------
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        if (grant && !credit_ret) begin
            credit_d = credit_q - 4'd1;
        end else if (!grant && credit_ret) begin
            if (credit_q == CREDIT_CEIL) begin
                credit_err_d = 1'b1;
            end else begin
                credit_d = credit_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_ARB;
            cur_src_q    <= 1'b0;
            run_cnt_q    <= '0;
            credit_q     <= CREDIT_CEIL;
            credit_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_src_q    <= cur_src_d;
            run_cnt_q    <= run_cnt_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Output capture: in CAP, cur_src_q is the source that was just granted
    // and its FIFO q holds the popped entry.
    // -----------------------------------------------------------------------
    logic [339:0] cap_data;
    assign cap_data = cur_src_q ? src1_q : src0_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            strobe_q   <= 1'b0;
            pkt_addr_q <= '0;
            ingress_q  <= '0;
            rloc_q     <= '0;
            eid_q      <= '0;
            meta_q     <= '0;
        end else begin
            strobe_q <= (state_q == ST_CAP);
            if (state_q == ST_CAP) begin
                pkt_addr_q <= {cur_src_q, cap_data[339:336]};
                ingress_q  <= cap_data[335:328];
                rloc_q     <= cap_data[327:200];
                eid_q      <= cap_data[199:72];
                meta_q     <= cap_data[71:0];
            end
        end
    end

    assign pkt_addr     = pkt_addr_q;
    assign pkt_addr_wr  = strobe_q;
    assign p2k_valid    = strobe_q;
    assign p2k_ingress  = ingress_q;
    assign p2k_rloc_src = rloc_q;
    assign p2k_eid_dst  = eid_q;
    assign p2k_metadata = meta_q;
    assign credit_cnt   = credit_q;
    assign credit_err   = credit_err_q;

    // -----------------------------------------------------------------------
    // Grant statistics
    // -----------------------------------------------------------------------
`ifdef META_SCHED_STATS_EN
    logic [31:0] gnt_cnt0_q, gnt_cnt1_q;

    // Counted at capture so the counter moves together with p2k_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else if (state_q == ST_CAP) begin
            if (cur_src_q) begin
                gnt_cnt1_q <= gnt_cnt1_q + 32'd1;
            end else begin
                gnt_cnt0_q <= gnt_cnt0_q + 32'd1;
            end
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`else
    assign gnt_cnt0 = '0;
    assign gnt_cnt1 = '0;
`endif

endmodule
